fire_responder: RTL and testbench
=================================

FIRE_RESPONDER -- requirements
Module: fire_responder

Interface
REQ-001 Parameter SIREN_HALF, default 2, SHALL set the siren half-period in clock cycles (legal range >= 1).
REQ-002 Parameter SPRINKLE_DELAY, default 8, SHALL set the number of ALERT cycles without ack before sprinklers engage (legal range >= 1).
REQ-003 Parameter SILENCE_TIME, default 16, SHALL set the number of SILENCED cycles before re-evaluating f_alarm (legal range >= 1).
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 f_alarm  input  1  SHALL be the alarm request from the fire detector, synchronous to clk.
REQ-007 ack  input  1  SHALL be the operator silence request, synchronous, level-sampled.
REQ-008 clear  input  1  SHALL be the operator all-clear request, synchronous, level-sampled.
REQ-009 siren  output  1  SHALL drive the audible siren.
REQ-010 sprinkler  output  1  SHALL drive the sprinkler valve.
REQ-011 state  output  2  SHALL expose the current FSM state encoding.
REQ-012 alarm_count  output  8  SHALL count IDLE->ALERT entries, saturating at 255.

Function
REQ-013 The FSM SHALL have four states: IDLE=0, ALERT=1, SPRINKLE=2, SILENCED=3.
REQ-014 In IDLE, siren=0 and sprinkler=0; f_alarm=1 sampled at edge N SHALL give state=ALERT and siren=1 after edge N (1-cycle latency), and alarm_count SHALL increment.
REQ-015 In ALERT and SPRINKLE, siren SHALL start high on state entry and toggle every SIREN_HALF cycles (defaults: 1,1,0,0,1,1,...).
REQ-016 ALERT SHALL latch: a drop of f_alarm SHALL NOT leave ALERT.
REQ-017 In ALERT, ack=1 SHALL move to SILENCED on the next edge.
REQ-018 In ALERT, once SPRINKLE_DELAY cycles have elapsed with no ack, the state SHALL go to SPRINKLE; sprinkler=1 on the edge after cycle SPRINKLE_DELAY of ALERT.
REQ-019 In ALERT, ack and delay expiry in the same cycle SHALL go to SILENCED; sprinkler SHALL remain 0.
REQ-020 In SPRINKLE, sprinkler=1 and siren keeps toggling; ack SHALL be ignored.
REQ-021 In SILENCED, siren=0 and sprinkler=0; a silence counter SHALL run for SILENCE_TIME cycles.
REQ-022 At silence expiry, f_alarm=1 SHALL return the FSM to ALERT with a fresh delay counter and restarted siren phase, without incrementing alarm_count; f_alarm=0 SHALL return it to IDLE.
REQ-023 In ALERT, SPRINKLE or SILENCED, clear=1 with f_alarm=0 SHALL go to IDLE on the next edge, and this SHALL take priority over ack and over timer expiry.
REQ-024 clear=1 while f_alarm=1 SHALL be ignored in every state.
REQ-025 In IDLE, ack and clear SHALL be ignored.
REQ-026 alarm_count SHALL hold at 255 on further entries.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state=IDLE, siren=0, sprinkler=0 and alarm_count=0, and clear all internal counters.
REQ-028 Reset asserted mid-operation (any state) SHALL discard the in-progress sequence; after release, the FSM SHALL resume from IDLE on the first edge.

Structure
REQ-029 The state encodings and parameter defaults SHALL live in a shared package fire_pkg.
REQ-030 One sub-module, fire_timer, SHALL be used for the delay and silence counters: a loadable down-counter with a done pulse, instantiated twice.

Verification (defaults)
REQ-031 Reset scenario: assert rst mid-clock-cycle -> siren=0, sprinkler=0, state=0 and alarm_count=0 before the next edge.
REQ-032 Sprinkler escalation: f_alarm=1 held, no ack -> state=1 after 1 edge; siren 1,1,0,0,1,1,0,0; state=2 and sprinkler=1 after 8 ALERT cycles; alarm_count=1.
REQ-033 Silence and re-arm: ack pulsed in the 3rd ALERT cycle with f_alarm=1 held -> state=3 and siren=0 next edge; state=1 again after 16 cycles; alarm_count still 1.
REQ-034 All-clear: in SPRINKLE, clear=1 with f_alarm=1 -> no change; drop f_alarm, then clear=1 -> state=0 and sprinkler=0 next edge.
REQ-035 Simultaneous events: ack in the 8th ALERT cycle (coincident with expiry) -> state=3 and sprinkler never 1.
REQ-036 Saturation: 256 alarm/clear cycles -> alarm_count=255 and holds at 255.

Source files
------------

// File: rtl/fire_pkg.sv
// fire_pkg: state encodings, parameter defaults and width helper for the fire responder
package fire_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALERT    = 2'd1,
    SPRINKLE = 2'd2,
    SILENCED = 2'd3
  } state_t;
  localparam int SIREN_HALF_DEF     = 2;
  localparam int SPRINKLE_DELAY_DEF = 8;
  localparam int SILENCE_TIME_DEF   = 16;
  function automatic int cw(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fire_timer.sv
// fire_timer: loadable down-counter; done pulses in the last enabled cycle of a loaded run
module fire_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] len,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= len;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign done = en && cnt == W'(1);
endmodule

// File: rtl/fire_responder.sv
// fire_responder: latching fire alarm FSM with siren, sprinkler escalation, silence and all-clear
module fire_responder
  import fire_pkg::*;
#(
  parameter int SIREN_HALF     = SIREN_HALF_DEF,
  parameter int SPRINKLE_DELAY = SPRINKLE_DELAY_DEF,
  parameter int SILENCE_TIME   = SILENCE_TIME_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       f_alarm,
  input  logic       ack,
  input  logic       clear,
  output logic       siren,
  output logic       sprinkler,
  output logic [1:0] state,
  output logic [7:0] alarm_count
);
  localparam int SW = cw(SIREN_HALF);
  localparam int DW = cw(SPRINKLE_DELAY);
  localparam int TW = cw(SILENCE_TIME);
  state_t st, nxt;
  logic dly_done, sil_done, all_clear, enter_alert, enter_sil, sounding, siren_q;
  logic [SW-1:0] sc;
  assign all_clear   = clear && !f_alarm;
  assign sounding    = st == ALERT || st == SPRINKLE;
  assign enter_alert = nxt == ALERT && st != ALERT;
  assign enter_sil   = nxt == SILENCED && st != SILENCED;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:     nxt = f_alarm ? ALERT : IDLE;
      ALERT:    nxt = all_clear ? IDLE : ack ? SILENCED : dly_done ? SPRINKLE : ALERT;
      SPRINKLE: nxt = all_clear ? IDLE : SPRINKLE;
      SILENCED: nxt = all_clear ? IDLE : sil_done ? (f_alarm ? ALERT : IDLE) : SILENCED;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) alarm_count <= '0;
    else if (st == IDLE && f_alarm && alarm_count != 8'hFF) alarm_count <= alarm_count + 8'd1;
  // phase restarts high on every ALERT entry and carries on unbroken into SPRINKLE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      siren_q <= 1'b0;
      sc      <= '0;
    end else if (enter_alert) begin
      siren_q <= 1'b1;
      sc      <= '0;
    end else if (sounding) begin
      if (sc == SW'(SIREN_HALF - 1)) begin
        siren_q <= ~siren_q;
        sc      <= '0;
      end else sc <= sc + SW'(1);
    end else begin
      siren_q <= 1'b0;
      sc      <= '0;
    end
  fire_timer #(.W(DW)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .load (enter_alert),
    .en   (st == ALERT),
    .len  (DW'(SPRINKLE_DELAY)),
    .done (dly_done)
  );
  fire_timer #(.W(TW)) u_sil (
    .clk  (clk),
    .rst  (rst),
    .load (enter_sil),
    .en   (st == SILENCED),
    .len  (TW'(SILENCE_TIME)),
    .done (sil_done)
  );
  assign siren     = siren_q && sounding;
  assign sprinkler = st == SPRINKLE;
  assign state     = st;
endmodule

// File: tb/tb_fire_responder.sv
// tb_fire_responder: directed checks of fire_responder with default parameters
module tb_fire_responder;
  logic clk = 1'b0, rst = 1'b1, f_alarm = 1'b0, ack = 1'b0, clear = 1'b0;
  logic siren, sprinkler;
  logic [1:0] state;
  logic [7:0] alarm_count;
  int vectors = 0, miscompares = 0;
  logic [7:0] pat = 8'b00110011;
  fire_responder dut (
    .clk         (clk),
    .rst         (rst),
    .f_alarm     (f_alarm),
    .ack         (ack),
    .clear       (clear),
    .siren       (siren),
    .sprinkler   (sprinkler),
    .state       (state),
    .alarm_count (alarm_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_siren", 8'(siren), 8'd0);
    chk("rst_sprk", 8'(sprinkler), 8'd0);
    chk("rst_count", alarm_count, 8'd0);
    f_alarm = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("esc_state", 8'(state), 8'd1);
      chk("esc_siren", 8'(siren), 8'(pat[i]));
      chk("esc_sprk", 8'(sprinkler), 8'd0);
      tick();
    end
    chk("sprk_state", 8'(state), 8'd2);
    chk("sprk_on", 8'(sprinkler), 8'd1);
    chk("sprk_siren", 8'(siren), 8'd1);
    chk("sprk_count", alarm_count, 8'd1);
    clear = 1'b1;
    ack = 1'b1;
    tick();
    chk("clr_ignored", 8'(state), 8'd2);
    ack = 1'b0;
    clear = 1'b0;
    f_alarm = 1'b0;
    tick();
    chk("sprk_hold", 8'(state), 8'd2);
    clear = 1'b1;
    tick();
    chk("allclr_state", 8'(state), 8'd0);
    chk("allclr_sprk", 8'(sprinkler), 8'd0);
    ack = 1'b1;
    tick();
    chk("idle_ign_state", 8'(state), 8'd0);
    chk("idle_ign_count", alarm_count, 8'd1);
    ack = 1'b0;
    clear = 1'b0;
    f_alarm = 1'b1;
    tick();
    chk("sil_entry", 8'(state), 8'd1);
    chk("sil_count", alarm_count, 8'd2);
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("sil_state", 8'(state), 8'd3);
    chk("sil_siren", 8'(siren), 8'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("sil_hold", 8'(state), 8'd3);
    tick();
    chk("rearm_state", 8'(state), 8'd1);
    chk("rearm_siren", 8'(siren), 8'd1);
    chk("rearm_count", alarm_count, 8'd2);
    f_alarm = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("latch_state", 8'(state), 8'd1);
    tick();
    chk("fresh_delay", 8'(state), 8'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr2_state", 8'(state), 8'd0);
    f_alarm = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("sim_pre", 8'(state), 8'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("sim_state", 8'(state), 8'd3);
    chk("sim_sprk", 8'(sprinkler), 8'd0);
    f_alarm = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("sil2_hold", 8'(state), 8'd3);
    tick();
    chk("sil_to_idle", 8'(state), 8'd0);
    chk("count3", alarm_count, 8'd3);
    f_alarm = 1'b1;
    tick();
    f_alarm = 1'b0;
    ack = 1'b1;
    clear = 1'b1;
    tick();
    ack = 1'b0;
    clear = 1'b0;
    chk("clr_over_ack", 8'(state), 8'd0);
    f_alarm = 1'b1;
    tick();
    chk("pre_rst_count", alarm_count, 8'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 8'(state), 8'd0);
    chk("arst_siren", 8'(siren), 8'd0);
    chk("arst_sprk", 8'(sprinkler), 8'd0);
    chk("arst_count", alarm_count, 8'd0);
    f_alarm = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst", 8'(state), 8'd0);
    f_alarm = 1'b1;
    tick();
    chk("resume_state", 8'(state), 8'd1);
    chk("resume_count", alarm_count, 8'd1);
    for (int i = 0; i < 255; i++) begin
      f_alarm = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      f_alarm = 1'b1;
      tick();
    end
    chk("sat_count", alarm_count, 8'd255);
    f_alarm = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    f_alarm = 1'b1;
    tick();
    chk("sat_state", 8'(state), 8'd1);
    chk("sat_hold", alarm_count, 8'd255);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
